// File: rtl/vid_timing_chk.sv
// Receive-side video timing checker: measures line/frame timing from sync rising edges,
// compares against programmed values, runs a lock FSM and checksums each frame's pixels.
module vid_timing_chk #(
    parameter int PW     = 8,
    parameter int H_BITS = 12,
    parameter int V_BITS = 12,
    parameter int CW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hs,
    input  logic              vs,
    input  logic              vld,
    input  logic [3*PW-1:0]   rgb,
    input  logic [H_BITS-1:0] exp_h_total,
    input  logic [H_BITS-1:0] exp_hs_width,
    input  logic [H_BITS-1:0] exp_hact_len,
    input  logic [V_BITS-1:0] exp_v_total,
    input  logic [V_BITS-1:0] exp_vs_width,
    input  logic [V_BITS-1:0] exp_vact_len,
    input  logic              err_clr,
    output logic              locked,
    output logic              frame_done,
    output logic [5:0]        err,
    output logic [15:0]       frame_cnt,
    output logic [CW-1:0]     chk_q
);

    localparam logic [H_BITS-1:0] H_MAX = '1;
    localparam logic [V_BITS-1:0] V_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

    logic              r_hs_d, r_vs_d, r_line_open;
    logic [H_BITS-1:0] r_line_cnt, r_hs_cnt, r_hs_w, r_hact;
    logic [V_BITS-1:0] r_v_total, r_vs_w, r_vact;
    logic [2:0]        r_fbits;
    logic [CW-1:0]     r_csum;
    state_t            r_state;

    logic              w_hs_rise, w_vs_rise, w_hs_fall, w_line_close;
    logic [2:0]        w_line_bits, w_fr_hbits;
    logic [V_BITS-1:0] w_vact_fin;
    logic [5:0]        w_close_bits, w_err_set;
    logic [CW-1:0]     w_pix;

    function automatic logic [H_BITS-1:0] inc_h(input logic [H_BITS-1:0] x);
        return (x == H_MAX) ? x : x + H_BITS'(1);
    endfunction

    function automatic logic [V_BITS-1:0] inc_v(input logic [V_BITS-1:0] x);
        return (x == V_MAX) ? x : x + V_BITS'(1);
    endfunction

    assign w_hs_rise    = hs & ~r_hs_d;
    assign w_vs_rise    = vs & ~r_vs_d;
    assign w_hs_fall    = ~hs & r_hs_d;
    // The very first hs rise after reset has no complete line behind it.
    assign w_line_close = w_hs_rise & r_line_open;
    assign w_pix        = CW'(rgb);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_line_bits = '0;
        w_vact_fin  = r_vact;
        if (w_line_close) begin
            w_line_bits[0] = (r_line_cnt != exp_h_total);
            w_line_bits[1] = (r_hs_w != exp_hs_width);
            w_line_bits[2] = (r_hact != '0) && (r_hact != exp_hact_len);
            if (r_hact != '0) w_vact_fin = inc_v(r_vact);
        end
    end

    // The line closing on a vs rise still belongs to the frame that is ending.
    assign w_fr_hbits   = r_fbits | w_line_bits;
    assign w_close_bits = {w_vact_fin != exp_vact_len, r_vs_w != exp_vs_width,
                           r_v_total != exp_v_total, w_fr_hbits};
    assign w_err_set    = (r_state == S_LOCKED && w_vs_rise) ? w_close_bits : '0;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_d      <= 1'b0;
            r_vs_d      <= 1'b0;
            r_line_open <= 1'b0;
            r_line_cnt  <= '0;
            r_hs_cnt    <= '0;
            r_hs_w      <= '0;
            r_hact      <= '0;
            r_fbits     <= '0;
            r_v_total   <= '0;
            r_vs_w      <= '0;
            r_vact      <= '0;
            r_csum      <= '0;
        end else begin
            r_hs_d <= hs;
            r_vs_d <= vs;

            if (w_hs_rise) begin
                r_line_open <= 1'b1;
                r_line_cnt  <= H_BITS'(1);
                r_hs_cnt    <= H_BITS'(1);
                r_hact      <= vld ? H_BITS'(1) : '0;
            end else begin
                r_line_cnt <= inc_h(r_line_cnt);
                if (hs)  r_hs_cnt <= inc_h(r_hs_cnt);
                if (vld) r_hact   <= inc_h(r_hact);
            end
            if (w_hs_fall) r_hs_w <= r_hs_cnt;

            // A coincident hs rise and vld on the vs rise cycle open the new frame.
            if (w_vs_rise) begin
                r_fbits   <= '0;
                r_v_total <= w_hs_rise ? V_BITS'(1) : '0;
                r_vs_w    <= w_hs_rise ? V_BITS'(1) : '0;
                r_vact    <= '0;
                r_csum    <= vld ? w_pix : '0;
            end else begin
                r_fbits <= w_fr_hbits;
                r_vact  <= w_vact_fin;
                if (w_hs_rise)      r_v_total <= inc_v(r_v_total);
                if (w_hs_rise & vs) r_vs_w    <= inc_v(r_vs_w);
                if (vld)            r_csum    <= r_csum + w_pix;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            err        <= '0;
            frame_cnt  <= '0;
            chk_q      <= '0;
        end else begin
            frame_done <= 1'b0;
            if (w_err_set != '0) err <= err | w_err_set;
            else if (err_clr)    err <= '0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_vs_rise) r_state <= S_ACQ;
                end
                S_ACQ: begin
                    if (w_vs_rise) begin
                        frame_done <= 1'b1;
                        chk_q      <= r_csum;
                        if (w_close_bits == '0) begin
                            r_state <= S_LOCKED;
                            locked  <= 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_vs_rise) begin
                        frame_done <= 1'b1;
                        chk_q      <= r_csum;
                        frame_cnt  <= frame_cnt + 16'd1;
                        if (w_close_bits != '0) begin
                            r_state <= S_ACQ;
                            locked  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vid_timing_chk.sv
// Bench for vid_timing_chk: drives synthetic video frames described at frame level and
// checks each frame_done against a frame-level reference model.
module tb_vid_timing_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs = 1'b0, vs = 1'b0, vld = 1'b0, err_clr = 1'b0;
    logic [23:0] rgb = '0;
    logic [11:0] exp_h_total, exp_hs_width, exp_hact_len;
    logic [11:0] exp_v_total, exp_vs_width, exp_vact_len;
    logic        locked, frame_done;
    logic [5:0]  err;
    logic [15:0] frame_cnt;
    logic [31:0] chk_q;

    vid_timing_chk #(.PW(8), .H_BITS(12), .V_BITS(12), .CW(32)) dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
        .exp_h_total(exp_h_total), .exp_hs_width(exp_hs_width), .exp_hact_len(exp_hact_len),
        .exp_v_total(exp_v_total), .exp_vs_width(exp_vs_width), .exp_vact_len(exp_vact_len),
        .err_clr(err_clr), .locked(locked), .frame_done(frame_done), .err(err),
        .frame_cnt(frame_cnt), .chk_q(chk_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] chk;
        logic [5:0]  err;
        logic        lk;
        logic [15:0] cnt;
    } ev_t;

    ev_t evq[$];
    ev_t mon_e;
    int  err_nz = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            mon_e.cyc = cyc;
            mon_e.chk = chk_q;
            mon_e.err = err;
            mon_e.lk  = locked;
            mon_e.cnt = frame_cnt;
            evq.push_back(mon_e);
        end
        if (err !== 6'b0) err_nz = err_nz + 1;
    end

    typedef struct {
        int ht, hw, ha, vt, vw, va, vs0, stretch, mode;
    } fr_t;

    int          n_pass = 0, n_total = 0;
    int          e_ht, e_hw, e_ha, e_vt, e_vw, e_va;
    logic        m_lock;
    int          m_cnt;
    logic [5:0]  m_err;
    fr_t         seq[$];
    logic [31:0] q_sum[$];
    int          q_vc[$];

    function automatic fr_t mk(int ht, int hw, int ha, int vt, int vw, int va,
                               int vs0, int stretch, int mode);
        fr_t f;
        f.ht = ht; f.hw = hw; f.ha = ha; f.vt = vt; f.vw = vw; f.va = va;
        f.vs0 = vs0; f.stretch = stretch; f.mode = mode;
        return f;
    endfunction

    function automatic fr_t nominal();
        return mk(61, 11, 11, 41, 11, 11, 20, -1, 0);
    endfunction

    // Which of the six checks a frame built from this description violates.
    function automatic logic [5:0] frame_bits(fr_t f);
        logic [5:0] b;
        b[0] = (f.ht != e_ht) || (f.stretch >= 0 && f.ht + 1 != e_ht);
        b[1] = (f.hw != e_hw);
        b[2] = (f.va > 0 && f.ha > 0 && f.ha != e_ha);
        b[3] = (f.vt != e_vt);
        b[4] = (f.vw != e_vw);
        b[5] = (((f.ha > 0) ? f.va : 0) != e_va);
        return b;
    endfunction

    task automatic model_reset();
        m_lock = 1'b0;
        m_cnt  = 0;
        m_err  = '0;
    endtask

    task automatic model_close(input logic [5:0] b, input logic clr);
        logic [5:0] set;
        set = m_lock ? b : 6'b0;
        if (set != 0) m_err = m_err | set;
        else if (clr) m_err = '0;
        if (m_lock) m_cnt = m_cnt + 1;
        m_lock = (b == 0);
    endtask

    task automatic set_exp(fr_t f);
        e_ht = f.ht; e_hw = f.hw; e_ha = f.ha; e_vt = f.vt; e_vw = f.vw; e_va = f.va;
        exp_h_total  = 12'(f.ht);
        exp_hs_width = 12'(f.hw);
        exp_hact_len = 12'(f.ha);
        exp_v_total  = 12'(f.vt);
        exp_vs_width = 12'(f.vw);
        exp_vact_len = 12'(f.va);
    endtask

    task automatic cyc_drive(input logic h, input logic v, input logic d,
                             input logic [23:0] p, input logic c);
        hs = h; vs = v; vld = d; rgb = p; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input fr_t f, output logic [31:0] sum, output int vs_cyc);
        logic [23:0] px;
        logic        d;
        sum    = '0;
        vs_cyc = cyc + 1;
        for (int l = 0; l < f.vt; l++) begin
            for (int c = 0; c < f.ht + ((l == f.stretch) ? 1 : 0); c++) begin
                d  = (l >= f.vs0) && (l < f.vs0 + f.va) && (c >= f.hw + 4) && (c < f.hw + 4 + f.ha);
                px = (f.mode != 0) ? 24'($urandom) : 24'(c - f.hw - 4 + 1);
                if (!d) px = '0;
                sum = sum + 32'(px);
                cyc_drive(c < f.hw, l < f.vw, d, px, 1'b0);
            end
        end
    endtask

    // Drives every queued frame, then a lone sync pulse that closes the last one.
    task automatic run_seq(input logic clr_last);
        logic [31:0] s;
        int          v;
        q_sum.delete();
        q_vc.delete();
        foreach (seq[i]) begin
            send_frame(seq[i], s, v);
            q_sum.push_back(s);
            q_vc.push_back(v);
        end
        q_vc.push_back(cyc + 1);
        cyc_drive(1'b1, 1'b1, 1'b0, '0, clr_last);
        repeat (4) cyc_drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hs = 1'b0; vs = 1'b0; vld = 1'b0; err_clr = 1'b0; rgb = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            hs = 1'b1; vs = 1'b1; vld = 1'b1; rgb = 24'h123456;
            @(posedge clk);
            #1 hs = 1'b0; vs = 1'b0;
            @(posedge clk);
            #1;
        end
        n_total++; if (locked !== 1'b0) $display("FAIL reset.locked: got %b want 0", locked); else n_pass++;
        n_total++; if (frame_done !== 1'b0) $display("FAIL reset.frame_done: got %b want 0", frame_done); else n_pass++;
        n_total++; if (err !== 6'h0) $display("FAIL reset.err: got %h want 00", err); else n_pass++;
        n_total++; if (frame_cnt !== 16'h0) $display("FAIL reset.frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
        n_total++; if (chk_q !== 32'h0) $display("FAIL reset.chk_q: got %h want 0", chk_q); else n_pass++;
        do_reset();
    endtask

    // Walks the queued frames through the model and compares every frame_done.
    task automatic test_nominal();
        int base, nz0;
        set_exp(nominal());
        do_reset();
        base = evq.size();
        nz0  = err_nz;
        seq.delete();
        repeat (4) seq.push_back(nominal());
        run_seq(1'b0);
        n_total++;
        if (evq.size() - base !== 4) $display("FAIL nominal.count: got %0d want 4", evq.size() - base); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            model_close(frame_bits(seq[k]), 1'b0);
            if (evq.size() > base + k) begin
                n_total++; if (evq[base+k].cyc !== q_vc[k+1]) $display("FAIL nominal.time[%0d]: got %0d want %0d", k, evq[base+k].cyc, q_vc[k+1]); else n_pass++;
                n_total++; if (evq[base+k].lk !== m_lock) $display("FAIL nominal.locked[%0d]: got %b want %b", k, evq[base+k].lk, m_lock); else n_pass++;
                n_total++; if (evq[base+k].cnt !== 16'(m_cnt)) $display("FAIL nominal.frame_cnt[%0d]: got %0d want %0d", k, evq[base+k].cnt, m_cnt); else n_pass++;
                n_total++; if (evq[base+k].chk !== q_sum[k]) $display("FAIL nominal.chk_q[%0d]: got %h want %h", k, evq[base+k].chk, q_sum[k]); else n_pass++;
                n_total++; if (evq[base+k].chk !== 32'd726) $display("FAIL nominal.static_chk[%0d]: got %0d want 726", k, evq[base+k].chk); else n_pass++;
            end
        end
        n_total++; if (err_nz !== nz0) $display("FAIL nominal.err_seen: got %0d cycles want 0", err_nz - nz0); else n_pass++;
    endtask

    task automatic test_checksum();
        int base;
        set_exp(mk(20, 3, 4, 5, 2, 1, 2, -1, 0));
        do_reset();
        base = evq.size();
        seq.delete();
        seq.push_back(mk(20, 3, 4, 5, 2, 1, 2, -1, 0));
        run_seq(1'b0);
        n_total++;
        if (evq.size() - base !== 1) $display("FAIL checksum.count: got %0d want 1", evq.size() - base);
        else if (evq[base].chk !== 32'h0000000A) $display("FAIL checksum.chk_q: got %h want 0000000a", evq[base].chk);
        else n_pass++;
    endtask

    task automatic test_random_pixels();
        int  base;
        fr_t f;
        set_exp(nominal());
        do_reset();
        base = evq.size();
        seq.delete();
        for (int i = 0; i < 3; i++) begin
            f      = nominal();
            f.mode = 1;
            f.vs0  = int'($urandom_range(11, 30));
            seq.push_back(f);
        end
        run_seq(1'b0);
        n_total++;
        if (evq.size() - base !== 3) $display("FAIL random.count: got %0d want 3", evq.size() - base); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            model_close(frame_bits(seq[k]), 1'b0);
            if (evq.size() > base + k) begin
                n_total++; if (evq[base+k].chk !== q_sum[k]) $display("FAIL random.chk_q[%0d]: got %h want %h", k, evq[base+k].chk, q_sum[k]); else n_pass++;
                n_total++; if (evq[base+k].lk !== m_lock) $display("FAIL random.locked[%0d]: got %b want %b", k, evq[base+k].lk, m_lock); else n_pass++;
            end
        end
    endtask

    task automatic test_line_fault();
        int  base;
        fr_t f;
        set_exp(nominal());
        do_reset();
        base = evq.size();
        seq.delete();
        seq.push_back(nominal());
        f         = nominal();
        f.stretch = int'($urandom_range(1, 39));
        seq.push_back(f);
        seq.push_back(nominal());
        seq.push_back(nominal());
        run_seq(1'b0);
        n_total++;
        if (evq.size() - base !== 4) $display("FAIL linefault.count: got %0d want 4", evq.size() - base); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            model_close(frame_bits(seq[k]), 1'b0);
            if (evq.size() > base + k) begin
                n_total++; if (evq[base+k].lk !== m_lock) $display("FAIL linefault.locked[%0d]: got %b want %b", k, evq[base+k].lk, m_lock); else n_pass++;
                n_total++; if (evq[base+k].err !== m_err) $display("FAIL linefault.err[%0d]: got %h want %h", k, evq[base+k].err, m_err); else n_pass++;
                n_total++; if (evq[base+k].cnt !== 16'(m_cnt)) $display("FAIL linefault.frame_cnt[%0d]: got %0d want %0d", k, evq[base+k].cnt, m_cnt); else n_pass++;
            end
        end
        n_total++; if (err !== 6'h01) $display("FAIL linefault.err_hold: got %h want 01", err); else n_pass++;
        cyc_drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cyc_drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        n_total++; if (err !== 6'h00) $display("FAIL linefault.err_clr: got %h want 00", err); else n_pass++;
    endtask

    task automatic test_vertical_fault();
        int base, nz0;
        set_exp(nominal());
        e_vw = 10;
        exp_vs_width = 12'd10;
        do_reset();
        base = evq.size();
        nz0  = err_nz;
        seq.delete();
        repeat (3) seq.push_back(nominal());
        run_seq(1'b0);
        n_total++;
        if (evq.size() - base !== 3) $display("FAIL vfault.count: got %0d want 3", evq.size() - base); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            model_close(frame_bits(seq[k]), 1'b0);
            if (evq.size() > base + k) begin
                n_total++; if (evq[base+k].lk !== m_lock) $display("FAIL vfault.locked[%0d]: got %b want %b", k, evq[base+k].lk, m_lock); else n_pass++;
                n_total++; if (evq[base+k].cyc !== q_vc[0] + (k + 1) * 41 * 61) $display("FAIL vfault.period[%0d]: got %0d want %0d", k, evq[base+k].cyc, q_vc[0] + (k + 1) * 41 * 61); else n_pass++;
            end
        end
        n_total++; if (err_nz !== nz0) $display("FAIL vfault.err_seen: got %0d cycles want 0", err_nz - nz0); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int base;
        set_exp(nominal());
        do_reset();
        seq.delete();
        repeat (5) seq.push_back(nominal());
        base = evq.size();
        fork
            run_seq(1'b0);
            begin
                // Lands in frame 1, line 11: past vs and hs, outside the active window.
                repeat (41 * 61 + 700) @(posedge clk);
                #3;
                n_total++; if (locked !== 1'b1) $display("FAIL midreset.pre_locked: got %b want 1", locked); else n_pass++;
                rst = 1'b1;
                #1;
                n_total++; if (locked !== 1'b0) $display("FAIL midreset.locked: got %b want 0", locked); else n_pass++;
                n_total++; if (frame_cnt !== 16'h0) $display("FAIL midreset.frame_cnt: got %0d want 0", frame_cnt); else n_pass++;
                n_total++; if (chk_q !== 32'h0) $display("FAIL midreset.chk_q: got %h want 0", chk_q); else n_pass++;
                n_total++; if ({err, frame_done} !== 7'h0) $display("FAIL midreset.err_fd: got %h want 0", {err, frame_done}); else n_pass++;
                repeat (2) @(posedge clk);
                #3 rst = 1'b0;
                base = evq.size();
            end
        join
        n_total++;
        if (evq.size() - base !== 3) $display("FAIL midreset.count: got %0d want 3", evq.size() - base); else n_pass++;
        if (evq.size() - base >= 2) begin
            n_total++; if (evq[base].cyc !== q_vc[3]) $display("FAIL midreset.first_done: got %0d want %0d", evq[base].cyc, q_vc[3]); else n_pass++;
            n_total++; if (evq[base].chk !== q_sum[2]) $display("FAIL midreset.chk_q: got %h want %h", evq[base].chk, q_sum[2]); else n_pass++;
            n_total++; if (evq[base+1].lk !== 1'b1) $display("FAIL midreset.relock: got %b want 1", evq[base+1].lk); else n_pass++;
        end
    endtask

    task automatic test_coincident();
        int  base;
        fr_t f;
        set_exp(nominal());
        do_reset();
        base = evq.size();
        seq.delete();
        seq.push_back(nominal());
        seq.push_back(nominal());
        f    = nominal();
        f.hw = 12;
        seq.push_back(f);
        run_seq(1'b1);
        n_total++;
        if (evq.size() - base !== 3) $display("FAIL coincident.count: got %0d want 3", evq.size() - base); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            model_close(frame_bits(seq[k]), k == 2);
            if (evq.size() > base + k) begin
                n_total++; if (evq[base+k].lk !== m_lock) $display("FAIL coincident.locked[%0d]: got %b want %b", k, evq[base+k].lk, m_lock); else n_pass++;
                n_total++; if (evq[base+k].err !== m_err) $display("FAIL coincident.err[%0d]: got %h want %h", k, evq[base+k].err, m_err); else n_pass++;
            end
        end
        n_total++; if (err !== 6'h02) $display("FAIL coincident.set_wins: got %h want 02", err); else n_pass++;
    endtask

    initial begin
        set_exp(nominal());
        test_reset();
        test_nominal();
        test_checksum();
        test_random_pixels();
        test_line_fault();
        test_vertical_fault();
        test_mid_reset();
        test_coincident();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
